// File: rtl/cb_config_sequencer_if.sv
// Config-stream and connection-block strobe bundle for cb_config_sequencer.
// master drives the stream side; slave is the sequencer.
interface cb_config_sequencer_if #(
    parameter int WORD_W     = 8,
    parameter int CONF_WIDTH = 24,
    parameter int NUM_BLOCKS = 4
);
    logic                  start;
    logic                  abort;
    logic [WORD_W-1:0]     in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [CONF_WIDTH-1:0] c;
    logic [NUM_BLOCKS-1:0] cset;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output start, abort, in_data, in_valid,
        input  in_ready, c, cset, busy, done, err
    );

    modport slave (
        input  start, abort, in_data, in_valid,
        output in_ready, c, cset, busy, done, err
    );
endinterface

// File: rtl/cb_config_sequencer.sv
// Packs a byte stream into per-block select words and strobes each block's cset.
// Define CFG_CHECKSUM_EN to require a trailing XOR check word per pass.
module cb_config_sequencer #(
    parameter int W          = 8,
    parameter int CONTROLIN  = 6,
    parameter int SEL_PER_IN = $clog2(W * 2),
    parameter int CONF_WIDTH = SEL_PER_IN * CONTROLIN,
    parameter int NUM_BLOCKS = 4,
    parameter int WORD_W     = 8,
    parameter int WPB        = (CONF_WIDTH + WORD_W - 1) / WORD_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cb_config_sequencer_if.slave bus
);
    localparam int AW  = WPB * WORD_W;
    localparam int WCW = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int BW  = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

`ifdef CFG_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT, S_CHECK} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} state_t;
`endif

    state_t                r_state;
    state_t                w_state_next;
    logic [WCW-1:0]        r_wcnt;
    logic [BW-1:0]         r_blk;
    logic [AW-1:0]         r_asm;
    logic [AW-1:0]         w_asm_next;
    logic [CONF_WIDTH-1:0] r_c;
    logic                  r_done;
    logic                  w_in_ready;
    logic                  w_busy;
    logic                  w_commit;
    logic                  w_last_word;
    logic                  w_last_blk;
    logic                  w_start;
    logic                  w_take;
    logic                  w_load_take;

    assign w_last_word = (r_wcnt == WCW'(WPB - 1));
    assign w_last_blk  = (r_blk == BW'(NUM_BLOCKS - 1));
    assign w_start     = (r_state == S_IDLE) && bus.start && !bus.abort;
    // abort beats a pending transfer: the word stays with upstream
    assign w_take      = w_in_ready && bus.in_valid && !bus.abort;
    assign w_load_take = w_take && (r_state == S_LOAD);

    always_comb begin
        w_asm_next = r_asm;
        w_asm_next[r_wcnt * WORD_W +: WORD_W] = bus.in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_busy       = 1'b1;
        w_commit     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (w_start) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                w_in_ready = 1'b1;
                if (bus.abort)
                    w_state_next = S_IDLE;
                else if (bus.in_valid && w_last_word)
                    w_state_next = S_COMMIT;
            end
            S_COMMIT: begin
                if (bus.abort) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_commit = 1'b1;
                    if (!w_last_blk)
                        w_state_next = S_LOAD;
                    else
`ifdef CFG_CHECKSUM_EN
                        w_state_next = S_CHECK;
`else
                        w_state_next = S_IDLE;
`endif
                end
            end
`ifdef CFG_CHECKSUM_EN
            S_CHECK: begin
                w_in_ready = 1'b1;
                if (bus.abort || bus.in_valid) w_state_next = S_IDLE;
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

`ifdef CFG_CHECKSUM_EN
    logic [WORD_W-1:0] r_xor;
    logic              r_err;
    logic              w_chk_take;

    assign w_chk_take = w_take && (r_state == S_CHECK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xor <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_xor <= '0;
                r_err <= 1'b0;
            end else if (w_load_take) begin
                r_xor <= r_xor ^ bus.in_data;
            end
            if (w_chk_take && (bus.in_data != r_xor)) r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt <= '0;
            r_blk  <= '0;
            r_asm  <= '0;
            r_c    <= '0;
            r_done <= 1'b0;
        end else begin
            if (w_start) begin
                r_wcnt <= '0;
                r_blk  <= '0;
                r_done <= 1'b0;
            end
            if (w_load_take) begin
                r_asm  <= w_asm_next;
                r_wcnt <= r_wcnt + 1'b1;
                if (w_last_word) r_c <= w_asm_next[CONF_WIDTH-1:0];
            end
            if (w_commit && !w_last_blk) begin
                r_blk  <= r_blk + 1'b1;
                r_wcnt <= '0;
            end
`ifdef CFG_CHECKSUM_EN
            if (w_chk_take && (bus.in_data == r_xor)) r_done <= 1'b1;
`else
            if (w_commit && w_last_blk) r_done <= 1'b1;
`endif
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.busy     = w_busy;
    assign bus.c        = r_c;
    assign bus.done     = r_done;
    assign bus.cset     = w_commit ? (NUM_BLOCKS'(1) << r_blk) : '0;
endmodule

// File: tb/tb_cb_config_sequencer.sv
// Bench for cb_config_sequencer: queue-based stream model plus directed pins.
// Build with CFG_CHECKSUM_EN defined to exercise the check-word path.
module tb_cb_config_sequencer;
    localparam int NB  = 4;
    localparam int WW  = 8;
    localparam int CW  = 24;
    localparam int WPB = 3;
    localparam int TOT = NB * WPB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cb_config_sequencer_if #(
        .WORD_W(WW), .CONF_WIDTH(CW), .NUM_BLOCKS(NB)
    ) bus ();

    cb_config_sequencer dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Model: the words of the current pass and the block awaiting its strobe
    bit          m_act  = 1'b0;
    bit          m_done = 1'b0;
    bit          m_err  = 1'b0;
    int          m_pend = -1;
    logic [CW-1:0] m_c  = '0;
    logic [7:0]  m_q[$];
    int          m_b;
    logic [63:0] m_v;

    int            log_cyc[$];
    logic [NB-1:0] log_cset[$];
    logic [CW-1:0] log_c[$];

    logic [7:0] feed_q[$];
    int         feed_idx = 0;
    int         vmode    = 3;
    bit         tgl      = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    function automatic logic [7:0] model_xor();
        logic [7:0] x = '0;
        foreach (m_q[i]) x ^= m_q[i];
        return x;
    endfunction

    function automatic logic [NB-1:0] exp_cset();
        if (m_pend >= 0 && !bus.abort) return NB'(1) << m_pend;
        return '0;
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 0; m_done = 0; m_err = 0; m_pend = -1;
            m_c = '0; m_q.delete();
        end else if (!m_act) begin
            if (bus.start && !bus.abort) begin
                m_act = 1; m_done = 0; m_err = 0; m_pend = -1;
                m_q.delete();
            end
        end else if (bus.abort) begin
            m_act = 0; m_pend = -1;
        end else if (m_pend >= 0) begin
`ifndef CFG_CHECKSUM_EN
            if (m_pend == NB - 1) begin m_act = 0; m_done = 1; end
`endif
            m_pend = -1;
        end else if (bus.in_valid) begin
            if (m_q.size() < TOT) begin
                m_q.push_back(bus.in_data);
                if (m_q.size() % WPB == 0) begin
                    m_b = m_q.size() / WPB - 1;
                    m_v = '0;
                    for (int j = 0; j < WPB; j++)
                        m_v |= 64'(m_q[m_b * WPB + j]) << (j * WW);
                    m_c    = m_v[CW-1:0];
                    m_pend = m_b;
                end
            end else begin
                if (bus.in_data == model_xor()) m_done = 1;
                else                            m_err  = 1;
                m_act = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.cset != '0) begin
            log_cyc.push_back(cyc);
            log_cset.push_back(bus.cset);
            log_c.push_back(bus.c);
        end
        if (chk_en) begin
            chk("busy", bus.busy, m_act);
            chk("in_ready", bus.in_ready, m_act && m_pend < 0);
            chk("cset", bus.cset, exp_cset());
            chk("c", bus.c, m_c);
            chk("done", bus.done, m_done);
            chk("err", bus.err, m_err);
        end
    end

    task automatic drive_word();
        if (vmode == 1) tgl = ~tgl;
        if (feed_idx < feed_q.size()) begin
            bus.in_data = feed_q[feed_idx];
            case (vmode)
                0:       bus.in_valid = 1'b1;
                1:       bus.in_valid = tgl;
                2:       bus.in_valid = 1'($urandom_range(0, 1));
                default: bus.in_valid = 1'b0;
            endcase
`ifdef CFG_CHECKSUM_EN
            if (vmode == 2 && m_act && m_pend < 0 && m_q.size() == TOT
                && $urandom_range(0, 1) == 1)
                bus.in_data = model_xor();
`endif
        end else begin
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic tick();
        bit took;
        @(negedge clk);
        took = bus.in_valid && bus.in_ready && !bus.abort;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        if (took) feed_idx++;
        drive_word();
    endtask

    task automatic load_feed(input int n, input bit rnd);
        feed_q.delete();
        feed_idx = 0;
        for (int i = 1; i <= n; i++)
            feed_q.push_back(rnd ? 8'($urandom) : 8'(i));
    endtask

    task automatic begin_pass(input int mode, output int s);
        vmode = mode;
        log_cyc.delete(); log_cset.delete(); log_c.delete();
        bus.start = 1'b1;
        s = cyc;
        drive_word();
    endtask

    logic [CW-1:0] exp_c[NB] = '{24'h030201, 24'h060504,
                                 24'h090807, 24'h0C0B0A};
    int s;
    int n4;

    initial begin
        bus.start = 0; bus.abort = 0; bus.in_valid = 0; bus.in_data = '0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Steady stream 0x01..0x0C
        load_feed(12, 0);
`ifdef CFG_CHECKSUM_EN
        feed_q.push_back(8'h0C);
`endif
        begin_pass(0, s);
        repeat (20) tick();
        chk("t1_ncommit", log_cyc.size(), NB);
        for (int k = 0; k < NB && k < log_cyc.size(); k++) begin
            chk("t1_cyc", log_cyc[k] - s, 4 * (k + 1));
            chk("t1_cset", log_cset[k], NB'(1) << k);
            chk("t1_c", log_c[k], exp_c[k]);
        end
        chk("t1_done", bus.done, 1);
        chk("t1_busy", bus.busy, 0);
        chk("t1_err", bus.err, 0);

        // Same pass, in_valid toggling
        load_feed(12, 0);
`ifdef CFG_CHECKSUM_EN
        feed_q.push_back(8'h0C);
`endif
        begin_pass(1, s);
        repeat (40) tick();
        chk("t2_ncommit", log_cyc.size(), NB);
        for (int k = 0; k < NB && k < log_cyc.size(); k++) begin
            chk("t2_cset", log_cset[k], NB'(1) << k);
            chk("t2_c", log_c[k], exp_c[k]);
        end
        chk("t2_done", bus.done, 1);

        // Abort in block 2 after one word
        load_feed(12, 0);
        begin_pass(0, s);
        repeat (10) tick();
        bus.abort = 1'b1;
        tick();
        vmode = 3;
        repeat (3) tick();
        n4 = 0;
        foreach (log_cset[i]) if (log_cset[i] == 4'b0100) n4++;
        chk("t3_ncommit", log_cyc.size(), 2);
        chk("t3_no_blk2", n4, 0);
        chk("t3_busy", bus.busy, 0);
        chk("t3_done", bus.done, 0);
        chk("t3_c", bus.c, 24'h060504);

        load_feed(12, 0);
`ifdef CFG_CHECKSUM_EN
        feed_q.push_back(8'h0C);
`endif
        begin_pass(0, s);
        repeat (20) tick();
        chk("t3r_ncommit", log_cyc.size(), NB);
        if (log_cyc.size() > 0) begin
            chk("t3r_cset0", log_cset[0], 4'b0001);
            chk("t3r_c0", log_c[0], 24'h030201);
        end
        chk("t3r_done", bus.done, 1);

        // start+abort in IDLE, then start while busy
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        tick();
        chk("t4_idle_busy", bus.busy, 0);
        chk("t4_idle_done", bus.done, 1);
        load_feed(12, 0);
`ifdef CFG_CHECKSUM_EN
        feed_q.push_back(8'h0C);
`endif
        begin_pass(0, s);
        repeat (6) tick();
        bus.start = 1'b1;
        repeat (16) tick();
        chk("t4_ncommit", log_cyc.size(), NB);
        if (log_cyc.size() == NB)
            chk("t4_last_cyc", log_cyc[NB-1] - s, 16);

        // Asynchronous reset during the first COMMIT
        load_feed(12, 0);
        begin_pass(0, s);
        repeat (4) tick();
        chk("t5_pre_cset", bus.cset, 4'b0001);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_cset", bus.cset, 0);
        chk("t5_c", bus.c, 0);
        chk("t5_busy", bus.busy, 0);
        chk("t5_ready", bus.in_ready, 0);
        chk("t5_done", bus.done, 0);
        chk("t5_err", bus.err, 0);
        feed_q.delete();
        feed_idx = 0;
        vmode = 3;
        @(posedge clk);
        #2 rst_n = 1'b1;
        drive_word();
        tick();

`ifdef CFG_CHECKSUM_EN
        // Wrong check word
        load_feed(12, 0);
        feed_q.push_back(8'h0D);
        begin_pass(0, s);
        repeat (20) tick();
        chk("t6_err", bus.err, 1);
        chk("t6_done", bus.done, 0);
`endif

        // Randomized traffic against the model
        load_feed(64, 1);
        vmode = 2;
        for (int i = 0; i < 2500; i++) begin
            tick();
            if (feed_q.size() - feed_idx < 8)
                for (int k = 0; k < 32; k++)
                    feed_q.push_back(8'($urandom));
            if ($urandom_range(0, 19) == 0) bus.start = 1'b1;
            if ($urandom_range(0, 79) == 0) bus.abort = 1'b1;
        end
        vmode = 3;
        tick();
        tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
